mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single SRAM-like memory bus between the instruction-fetch port and the data (MEM-stage) port.
- Sequences each transfer through an address phase and a data phase.
- Drops instruction responses made stale by a pipeline flush.
- Generates stallreq_for_fetch and stallreq_for_memory for the pipeline control block.

Parameters:
- ADDR_W, 32, address width of both requesters and the bus.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush (exception/eret) from control block
- inst_req  in  1  fetch request; held with inst_addr until inst_valid
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetched word, meaningful only with inst_valid
- inst_valid  out  1  one-cycle completion pulse for fetch
- data_req  in  1  data request; held with payload until data_valid
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  DATA_W/8  byte enables for stores
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data, meaningful only with data_valid
- data_valid  out  1  one-cycle completion pulse for data
- bus_req  out  1  bus request, held until bus_addr_ok
- bus_wr  out  1  registered copy of granted wr (0 for fetch)
- bus_size  out  2  registered size (2 for fetch)
- bus_wstrb  out  DATA_W/8  registered strobes (0 for fetch)
- bus_addr  out  ADDR_W  registered address
- bus_wdata  out  DATA_W  registered write data
- bus_addr_ok  in  1  slave accepted address phase
- bus_data_ok  in  1  slave completed data phase
- bus_rdata  in  DATA_W  read data, valid with bus_data_ok
- stallreq_for_fetch  out  1  fetch stall request
- stallreq_for_memory  out  1  MEM stall request

Behaviour:
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- Reset (async, resetn = 0):
  - state = IDLE; drop = 0; last_grant = data.
  - All bus_* registers = 0.
  - inst_valid = data_valid = 0; both stall outputs = 0.
  - Any in-flight bus transfer is abandoned; the slave resets in the same domain.
- IDLE arbitration:
  - data_req = 1 -> D_ADDR; else inst_req = 1 -> I_ADDR (default fixed data priority).
  - On the grant edge, latch the payload into the bus_* registers. Fetch uses wr = 0, size = 2, wstrb = 0, wdata = 0.
- bus_req = 1 exactly in I_ADDR and D_ADDR.
  - Payload stays stable while bus_req = 1.
  - bus_req is never withdrawn before bus_addr_ok, including on flush.
- Phase transitions:
  - *_ADDR with bus_addr_ok = 1 -> matching *_DATA.
  - *_DATA with bus_data_ok = 1 -> IDLE.
  - bus_data_ok outside *_DATA is ignored.
- Completion signals:
  - inst_valid = (state == I_DATA) & bus_data_ok & ~drop, combinational.
  - data_valid = (state == D_DATA) & bus_data_ok, combinational.
  - inst_rdata and data_rdata = bus_rdata, pass-through.
- Minimum latency, req to valid = 3 cycles: grant edge, addr_ok cycle, data_ok cycle. A new grant is possible in the cycle after completion. There are no back-to-back grants without IDLE.
- Stalls (combinational):
  - stallreq_for_fetch = inst_req & ~inst_valid.
  - stallreq_for_memory = data_req & ~data_valid.
- Flush:
  - flush = 1 in I_ADDR or I_DATA sets drop.
  - The transfer still completes on the bus; its inst_valid is suppressed.
  - drop clears on entry to IDLE.
  - flush in IDLE, D_ADDR or D_DATA has no effect; data transfers are never cancelled.
  - flush in the same cycle as the I_DATA bus_data_ok also suppresses that inst_valid.
- Requesters may drop req only after their valid pulse. Dropping earlier is illegal: the arbiter completes the transfer and any response pulse it produces is ignored.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: a last_grant register is updated on every grant. When inst_req and data_req are both 1 in IDLE, the grant goes to the port not granted last, which prevents fetch starvation under back-to-back loads.
- Undefined: fixed data-over-inst priority and no last_grant register.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Lone fetch to 0xBFC00000, slave addr_ok at cycle 1, data_ok with rdata 0x3C1D0001 at cycle 2 -> bus_req high exactly 1 cycle; inst_valid and inst_rdata = 0x3C1D0001 at cycle 2; stallreq_for_fetch = 1 for cycles 0-1 and 0 at cycle 2.
- inst_req and data_req both raised in IDLE, load to 0x80001000 -> D_ADDR granted first; fetch granted the cycle after data_valid. With ARB_RR_EN and last_grant = data, fetch is granted first.
- Store: size 2, wstrb 0xF, wdata 0xDEADBEEF, addr 0x80002000; slave holds addr_ok low 4 cycles -> bus_req and payload stable all 4 cycles, bus_wr = 1; data_valid when data_ok arrives.
- flush asserted one cycle after a fetch grant -> transfer completes on the bus; inst_valid stays 0; drop clears; a following fetch to 0xBFC00380 returns a normal inst_valid.
- resetn pulled low during D_DATA -> bus_req, data_valid and both stalls go 0 immediately; state IDLE after release; a new request is granted normally.
- flush during D_ADDR -> data transfer unaffected; data_valid still produced.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Pipeline request ports, control signals and SRAM-like bus of mem_bus_arbiter.
// master = arbiter view, slave = view of the pipeline plus memory slave.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              flush;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_valid;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_valid;

  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [STRB_W-1:0] bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  logic              stallreq_for_fetch;
  logic              stallreq_for_memory;

  modport master (
    input  flush,
    input  inst_req, inst_addr,
    output inst_rdata, inst_valid,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_rdata, data_valid,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output stallreq_for_fetch, stallreq_for_memory
  );

  modport slave (
    output flush,
    output inst_req, inst_addr,
    input  inst_rdata, inst_valid,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_rdata, data_valid,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  stallreq_for_fetch, stallreq_for_memory
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch and MEM-stage ports (addr phase, then data phase).
// Define ARB_RR_EN to alternate grants when both ports request; default is fixed data priority.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  mem_bus_arbiter_if.master  arb
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } payload_t;

  state_t   state;
  state_t   state_nxt;
  logic     drop;
  logic     drop_nxt;
  logic     bus_req_q;
  payload_t payload_q;
  payload_t payload_nxt;
  logic     grant_inst_c;
  logic     grant_data_c;

  // IDLE arbitration between the two requesters
`ifdef ARB_RR_EN
  logic last_grant;  // 1: data port won the most recent grant

  always_comb begin
    grant_inst_c = 1'b0;
    grant_data_c = 1'b0;
    if (state == IDLE) begin
      if (arb.data_req && arb.inst_req) begin
        grant_data_c = !last_grant;
        grant_inst_c = last_grant;
      end else begin
        grant_data_c = arb.data_req;
        grant_inst_c = arb.inst_req;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (grant_data_c) begin
      last_grant <= 1'b1;
    end else if (grant_inst_c) begin
      last_grant <= 1'b0;
    end
  end
`else
  always_comb begin
    grant_inst_c = 1'b0;
    grant_data_c = 1'b0;
    if (state == IDLE) begin
      grant_data_c = arb.data_req;
      grant_inst_c = arb.inst_req && !arb.data_req;
    end
  end
`endif

  // Next state and flush-drop tracking
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    case (state)
      IDLE: begin
        if (grant_data_c) begin
          state_nxt = D_ADDR;
        end else if (grant_inst_c) begin
          state_nxt = I_ADDR;
        end
      end
      I_ADDR: if (arb.bus_addr_ok) state_nxt = I_DATA;
      I_DATA: if (arb.bus_data_ok) state_nxt = IDLE;
      D_ADDR: if (arb.bus_addr_ok) state_nxt = D_DATA;
      D_DATA: if (arb.bus_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == IDLE) begin
      drop_nxt = 1'b0;
    end else if (arb.flush && (state == I_ADDR || state == I_DATA)) begin
      drop_nxt = 1'b1;
    end
  end

  // Payload captured only on the grant edge, so it holds for the whole address phase
  always_comb begin
    payload_nxt = payload_q;
    if (grant_data_c) begin
      payload_nxt.wr    = arb.data_wr;
      payload_nxt.size  = arb.data_size;
      payload_nxt.wstrb = arb.data_wstrb;
      payload_nxt.addr  = arb.data_addr;
      payload_nxt.wdata = arb.data_wdata;
    end else if (grant_inst_c) begin
      payload_nxt.wr    = 1'b0;
      payload_nxt.size  = 2'd2;
      payload_nxt.wstrb = STRB_W'(0);
      payload_nxt.addr  = arb.inst_addr;
      payload_nxt.wdata = DATA_W'(0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      drop      <= 1'b0;
      bus_req_q <= 1'b0;
      payload_q <= '0;
    end else begin
      state     <= state_nxt;
      drop      <= drop_nxt;
      bus_req_q <= (state_nxt == I_ADDR) || (state_nxt == D_ADDR);
      payload_q <= payload_nxt;
    end
  end

  assign arb.bus_req   = bus_req_q;
  assign arb.bus_wr    = payload_q.wr;
  assign arb.bus_size  = payload_q.size;
  assign arb.bus_wstrb = payload_q.wstrb;
  assign arb.bus_addr  = payload_q.addr;
  assign arb.bus_wdata = payload_q.wdata;

  // A flush in the completing cycle also kills the fetch response
  assign arb.inst_valid = (state == I_DATA) && arb.bus_data_ok && !drop && !arb.flush;
  assign arb.data_valid = (state == D_DATA) && arb.bus_data_ok;
  assign arb.inst_rdata = arb.bus_rdata;
  assign arb.data_rdata = arb.bus_rdata;

  // Stalls are forced low while reset is held
  assign arb.stallreq_for_fetch  = resetn && arb.inst_req && !arb.inst_valid;
  assign arb.stallreq_for_memory = resetn && arb.data_req && !arb.data_valid;

endmodule
